// File: rtl/reg_file_alu_pkg.sv
// Shared definitions for the reg_file_alu datapath slice: default widths
// and the ALU operation encoding driven by the control unit.
package reg_file_alu_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic [1:0] {
      ALU_AND = 2'b00,
      ALU_OR  = 2'b01,
      ALU_ADD = 2'b10,
      ALU_SUB = 2'b11
   } alu_op_e;

endpackage : reg_file_alu_pkg

// File: rtl/reg_file_alu_alu.sv
// Combinational 4-function ALU; add/sub wrap modulo 2**DATA_W with no flags.
module alu
   import reg_file_alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  alu_op_e                  op,
   output logic signed [DATA_W-1:0] y
);

   // Operation select
   always_comb begin
      y = '0;
      unique case (op)
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         default: y = '0;
      endcase
   end

endmodule : alu

// File: rtl/reg_file_alu.sv
// Register file (2 read, 1 write) feeding the ALU; the ALU result is both the
// block output and the write-back data. Reads are unbypassed and combinational.
module reg_file_alu
   import reg_file_alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        RA1,
   input  logic [ADDR_W-1:0]        RA2,
   input  logic [ADDR_W-1:0]        WA,
   input  logic signed [DATA_W-1:0] external_data_in,
   input  logic [1:0]               ALUcontrol,
   input  logic                     regwrite,
   input  logic                     ALUsrc,
   output logic signed [DATA_W-1:0] ALUresult
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]        regs_q [NUM_REGS];
   logic [DATA_W-1:0]        regs_d [NUM_REGS];
   logic signed [DATA_W-1:0] operand_a_s;
   logic signed [DATA_W-1:0] operand_b_s;
   logic signed [DATA_W-1:0] alu_y_s;
   alu_op_e                  alu_op_s;

   assign alu_op_s = alu_op_e'(ALUcontrol);

   // Operand fetch: A from port 1, B from port 2 or the external operand
   always_comb begin
      operand_a_s = $signed(regs_q[RA1]);
      if (ALUsrc) begin
         operand_b_s = external_data_in;
      end else begin
         operand_b_s = $signed(regs_q[RA2]);
      end
   end

   alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a  (operand_a_s),
      .b  (operand_b_s),
      .op (alu_op_s),
      .y  (alu_y_s)
   );

   assign ALUresult = alu_y_s;

   // Write-back next state: only the addressed entry changes, and only when enabled
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (regwrite) begin
         regs_d[WA] = alu_y_s;
      end else begin
         regs_d[WA] = regs_q[WA];
      end
   end

   // Register storage; reset clears every entry without waiting for clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule : reg_file_alu

// File: tb/tb_reg_file_alu.sv
// Directed self-checking bench for reg_file_alu with hand-computed expectations.
module tb_reg_file_alu;

   logic              clk;
   logic              rst_n;
   logic [3:0]        RA1;
   logic [3:0]        RA2;
   logic [3:0]        WA;
   logic signed [7:0] external_data_in;
   logic [1:0]        ALUcontrol;
   logic              regwrite;
   logic              ALUsrc;
   logic signed [7:0] ALUresult;

   int checks_cnt;
   int errors_cnt;

   logic [7:0] rd_val;
   logic [7:0] chain_exp [13];

   reg_file_alu dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .RA1              (RA1),
      .RA2              (RA2),
      .WA               (WA),
      .external_data_in (external_data_in),
      .ALUcontrol       (ALUcontrol),
      .regwrite         (regwrite),
      .ALUsrc           (ALUsrc),
      .ALUresult        (ALUresult)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read a register through the datapath: reg[a] | 0, write disabled
   task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
      regwrite         = 1'b0;
      RA1              = a;
      ALUsrc           = 1'b1;
      external_data_in = 8'sd0;
      ALUcontrol       = 2'b01;
      #1;
      v = ALUresult;
   endtask

   task automatic drive(input logic [3:0] wa, input logic [3:0] ra1, input logic [3:0] ra2,
                        input logic src, input logic [7:0] ext, input logic [1:0] op,
                        input logic we);
      WA               = wa;
      RA1              = ra1;
      RA2              = ra2;
      ALUsrc           = src;
      external_data_in = ext;
      ALUcontrol       = op;
      regwrite         = we;
      #1;
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      chain_exp  = '{8'd0, 8'd1, 8'd3, 8'd3, 8'd5, 8'd5, 8'd7, 8'd7,
                     8'd9, 8'd9, 8'd11, 8'd11, 8'd13};
      rst_n = 1'b0;
      drive(4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 2'b10, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Load reg3 with a nonzero value, then reset asynchronously mid-cycle
      drive(4'd3, 4'd0, 4'd0, 1'b1, 8'h55, 2'b01, 1'b1);
      tick();
      read_reg(4'd3, rd_val);
      check_val("pre_reset_reg3", rd_val, 8'h55);
      #2;
      rst_n = 1'b0;
      #1;
      read_reg(4'd3, rd_val);
      check_val("async_reset_reg3", rd_val, 8'h00);
      drive(4'd3, 4'd3, 4'd3, 1'b0, 8'h00, 2'b10, 1'b0);
      check_val("reset_add_zero", ALUresult, 8'h00);
      // A write during reset must be discarded
      drive(4'd3, 4'd0, 4'd0, 1'b1, 8'h77, 2'b01, 1'b1);
      tick();
      rst_n = 1'b1;
      read_reg(4'd3, rd_val);
      check_val("write_in_reset_dropped", rd_val, 8'h00);
      tick();

      // Immediate OR chain
      drive(4'd0, 4'd1, 4'd0, 1'b1, 8'h00, 2'b00, 1'b1);
      tick();
      for (int i = 1; i <= 12; i++) begin
         drive(4'(i), 4'd1, 4'd0, 1'b1, 8'(i), 2'b01, 1'b1);
         tick();
      end
      for (int i = 0; i <= 12; i++) begin
         read_reg(4'(i), rd_val);
         check_val($sformatf("chain_reg%0d", i), rd_val, chain_exp[i]);
      end

      // Register-register operations
      drive(4'd13, 4'd6, 4'd9, 1'b0, 8'h00, 2'b01, 1'b1);
      check_val("rr_or", ALUresult, 8'd15);
      tick();
      drive(4'd14, 4'd6, 4'd10, 1'b0, 8'h00, 2'b10, 1'b1);
      check_val("rr_add", ALUresult, 8'd18);
      tick();
      drive(4'd15, 4'd6, 4'd11, 1'b0, 8'h00, 2'b11, 1'b1);
      check_val("rr_sub", ALUresult, 8'hFC);
      tick();
      read_reg(4'd13, rd_val);
      check_val("reg13", rd_val, 8'd15);
      read_reg(4'd14, rd_val);
      check_val("reg14", rd_val, 8'd18);
      read_reg(4'd15, rd_val);
      check_val("reg15", rd_val, 8'hFC);
      drive(4'd0, 4'd13, 4'd14, 1'b0, 8'h00, 2'b00, 1'b0);
      check_val("rr_and", ALUresult, 8'd2);

      // Wrap-around at the signed limits
      drive(4'd2, 4'd0, 4'd0, 1'b1, 8'h7F, 2'b01, 1'b1);
      tick();
      drive(4'd2, 4'd2, 4'd0, 1'b1, 8'h01, 2'b10, 1'b1);
      check_val("wrap_add", ALUresult, 8'h80);
      tick();
      drive(4'd2, 4'd2, 4'd0, 1'b1, 8'h01, 2'b11, 1'b0);
      check_val("wrap_sub", ALUresult, 8'h7F);

      // Write enable low across edges leaves the target untouched
      drive(4'd4, 4'd0, 4'd0, 1'b1, 8'hAA, 2'b01, 1'b0);
      tick();
      tick();
      read_reg(4'd4, rd_val);
      check_val("we_low_reg4", rd_val, 8'd5);

      // Self-increment: old value until the edge, exactly +1 per edge
      drive(4'd5, 4'd5, 4'd0, 1'b1, 8'h01, 2'b10, 1'b1);
      check_val("rdw_old_value", ALUresult, 8'd6);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check_val($sformatf("incr_edge%0d", k), ALUresult, 8'(6 + k));
      end
      read_reg(4'd5, rd_val);
      check_val("incr_final_reg5", rd_val, 8'd8);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule : tb_reg_file_alu
